intpol2_job_sched: RTL and testbench

INTPOL2_JOB_SCHED -- requirements
Module: intpol2_job_sched

---
 rtl/intpol2_job_sched.sv | 142 ++++++++++++++
 tb/tb_intpol2_job_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/intpol2_job_sched.sv
// Job scheduler for the interpolator core: arbitrates two requesters,
// loads the winning config, starts the core and watches for completion.
module intpol2_job_sched #(
  parameter int unsigned CONFIG_WIDTH = 32,
  parameter int unsigned WDOG_WIDTH   = 16,
  parameter int unsigned WDOG_LIMIT   = 16'hFFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req,
  input  logic [4*CONFIG_WIDTH-1:0]   cfg0_i,
  input  logic [4*CONFIG_WIDTH-1:0]   cfg1_i,
  input  logic [7:0]                  core_status,
  output logic [4*CONFIG_WIDTH-1:0]   core_cfg,
  output logic                        core_start,
  output logic [1:0]                  gnt,
  output logic [1:0]                  job_done,
  output logic                        busy,
  output logic                        owner,
  output logic                        len_err,
  output logic                        wdog_err
);

  localparam int unsigned CFG_W = 4 * CONFIG_WIDTH;
  localparam logic [WDOG_WIDTH-1:0] WDOG_MAX = WDOG_WIDTH'(WDOG_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                  state;
  logic [WDOG_WIDTH-1:0]   wdog;
  logic                    pick;
  logic [CFG_W-1:0]        pick_cfg;
  logic                    ilen_zero;
  logic                    wdog_expired;
  logic                    core_done;
  logic                    core_busy;
  logic                    unused_status;

  assign core_done     = core_status[0];
  assign core_busy     = core_status[1];
  assign unused_status = ^core_status[7:2];
  assign ilen_zero     = (core_cfg[CFG_W-1 -: CONFIG_WIDTH] == '0);
  assign wdog_expired  = (wdog == WDOG_MAX);

  // Round-robin pick: a lone request always wins, a conflict goes to the
  // requester that did not own the previous job.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) begin
      pick = ~owner;
    end
    pick_cfg = pick ? cfg1_i : cfg0_i;
  end

  // Scheduler FSM with registered outputs and watchdog counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      core_cfg   <= '0;
      core_start <= 1'b0;
      gnt        <= 2'b00;
      job_done   <= 2'b00;
      busy       <= 1'b0;
      owner      <= 1'b1;
      len_err    <= 1'b0;
      wdog_err   <= 1'b0;
      wdog       <= '0;
    end else begin
      gnt        <= 2'b00;
      core_start <= 1'b0;
      job_done   <= 2'b00;
      len_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= {pick, ~pick};
            core_cfg <= pick_cfg;
            owner    <= pick;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (ilen_zero) begin
            len_err  <= 1'b1;
            job_done <= {owner, ~owner};
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= START;
          end
        end
        START: begin
          core_start <= 1'b1;
          wdog       <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (wdog_expired) begin
            wdog_err <= 1'b1;
            job_done <= {owner, ~owner};
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            if (wdog != '1) begin
              wdog <= wdog + WDOG_WIDTH'(1);
            end
            // A very short job may show done without ever showing busy.
            if (core_busy || core_done) begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (core_done) begin
            job_done <= {owner, ~owner};
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (wdog_expired) begin
            wdog_err <= 1'b1;
            job_done <= {owner, ~owner};
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (wdog != '1) begin
            wdog <= wdog + WDOG_WIDTH'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intpol2_job_sched.sv
// Scoreboard bench for intpol2_job_sched: stimulus pushes expected output
// events, a negedge monitor pops and compares each event the DUT presents.
module tb_intpol2_job_sched;

  localparam int unsigned CW    = 32;
  localparam int unsigned CFG_W = 4 * CW;

  // Event word layout: {gnt[1:0], core_start, job_done[1:0], len_err}
  localparam logic [5:0] EV_GNT0 = 6'b01_0_00_0;
  localparam logic [5:0] EV_GNT1 = 6'b10_0_00_0;
  localparam logic [5:0] EV_CS   = 6'b00_1_00_0;
  localparam logic [5:0] EV_JD0  = 6'b00_0_01_0;
  localparam logic [5:0] EV_JD1  = 6'b00_0_10_0;
  localparam logic [5:0] EV_ZL1  = 6'b00_0_10_1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [CFG_W-1:0] cfg0 = '0;
  logic [CFG_W-1:0] cfg1 = '0;
  logic [7:0]       core_status;
  logic [CFG_W-1:0] core_cfg;
  logic             core_start;
  logic [1:0]       gnt;
  logic [1:0]       job_done;
  logic             busy;
  logic             owner;
  logic             len_err;
  logic             wdog_err;

  intpol2_job_sched #(
    .CONFIG_WIDTH (CW),
    .WDOG_WIDTH   (16),
    .WDOG_LIMIT   (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .cfg0_i      (cfg0),
    .cfg1_i      (cfg1),
    .core_status (core_status),
    .core_cfg    (core_cfg),
    .core_start  (core_start),
    .gnt         (gnt),
    .job_done    (job_done),
    .busy        (busy),
    .owner       (owner),
    .len_err     (len_err),
    .wdog_err    (wdog_err)
  );

  always #5 clk = ~clk;

  // Core model: mode 0 normal (busy 2 cycles after start, done 10 later),
  // mode 1 fast (done right after start), mode 2 hung (never responds).
  int         mode = 0;
  int         t;
  logic       active;
  logic [1:0] st;
  assign core_status = {6'd0, st};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= 2'b00; active <= 1'b0; t <= 0;
    end else if (core_start) begin
      t <= 0;
      active <= (mode == 0);
      st <= (mode == 1) ? 2'b01 : 2'b00;
    end else if (job_done != 2'b00) begin
      active <= 1'b0; st <= 2'b00;
    end else if (active) begin
      t <= t + 1;
      if (t + 1 == 2) st <= 2'b10;
      else if (t + 1 == 12) begin st <= 2'b01; active <= 1'b0; end
    end
  end

  typedef struct {
    string       name;
    logic [5:0]  ev;
    int          delta;
    logic        own;
    logic [31:0] ilen;
    logic        wd;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  task automatic push(input string n, input logic [5:0] ev, input int d,
                      input logic own, input logic [31:0] il, input logic wd);
    exp_t e;
    e.name = n; e.ev = ev; e.delta = d; e.own = own; e.ilen = il; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic chk(input string n, input logic [159:0] act, input logic [159:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask

  // Monitor: every cycle with an output pulse is matched against the queue.
  always @(negedge clk) begin
    logic [5:0] ev;
    int         d;
    exp_t       e;
    cyc++;
    ev = {gnt, core_start, job_done, len_err};
    if (!rst && ev != 6'd0) begin
      d = cyc - last_cyc;
      nchk++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_event: got ev=%b at cycle %0d want no event", ev, cyc);
      end else begin
        e = sb.pop_front();
        if (ev === e.ev && d == e.delta && owner === e.own &&
            core_cfg[CFG_W-1 -: CW] === e.ilen && wdog_err === e.wd) begin
          npass++;
        end else begin
          $display("FAIL %s: got ev=%b d=%0d own=%0b ilen=%0d wd=%0b want ev=%b d=%0d own=%0b ilen=%0d wd=%0b",
                   e.name, ev, d, owner, core_cfg[CFG_W-1 -: CW], wdog_err,
                   e.ev, e.delta, e.own, e.ilen, e.wd);
        end
      end
      last_cyc = cyc;
    end
  end

  function automatic logic [CFG_W-1:0] mk_cfg(input logic [31:0] ilen, input logic [31:0] ix);
    return {ilen, ix * 32'd2, ix, 32'h0000_0001};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_req(input logic [1:0] r);
    tick();
    req = r;
    last_cyc = cyc;
  endtask

  task automatic wait_gnt(input string n, input int num);
    int got = 0;
    for (int i = 0; i < 300 && got < num; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) got++;
    end
    chk({n, "_gnt_count"}, 160'(got), 160'(num));
    req = 2'b00;
  endtask

  task automatic drain(input string n, input int lim);
    int i = 0;
    while ((sb.size() != 0 || busy) && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk({n, "_drained"}, 160'(sb.size()), 160'd0);
    chk({n, "_busy_low"}, 160'(busy), 160'd0);
  endtask

  task automatic chk_reset_vals(input string n);
    chk(n, {core_cfg, core_start, gnt, job_done, busy, owner, len_err, wdog_err},
        {128'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic do_reset(input string n);
    tick();
    rst = 1'b1;
    req = 2'b00;
    tick();
    chk_reset_vals(n);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    cfg0 = mk_cfg(32'd8, 32'h10);
    cfg1 = mk_cfg(32'd5, 32'h20);
    repeat (3) tick();
    chk_reset_vals("reset_state");
    rst = 1'b0;
    tick();

    // Single job from requester 0
    push("t1_gnt", EV_GNT0, 2, 1'b0, 32'd8, 1'b0);
    push("t1_start", EV_CS, 2, 1'b0, 32'd8, 1'b0);
    push("t1_done", EV_JD0, 14, 1'b0, 32'd8, 1'b0);
    start_req(2'b01);
    wait_gnt("t1", 1);
    drain("t1", 100);

    // Contention from reset: order 0,1,0,1
    do_reset("t2_reset");
    for (int j = 0; j < 4; j++) begin
      push($sformatf("t2_gnt%0d", j), (j % 2 == 0) ? EV_GNT0 : EV_GNT1, (j == 0) ? 2 : 1,
           1'(j % 2), (j % 2 == 0) ? 32'd8 : 32'd5, 1'b0);
      push($sformatf("t2_start%0d", j), EV_CS, 2, 1'(j % 2),
           (j % 2 == 0) ? 32'd8 : 32'd5, 1'b0);
      push($sformatf("t2_done%0d", j), (j % 2 == 0) ? EV_JD0 : EV_JD1, 14, 1'(j % 2),
           (j % 2 == 0) ? 32'd8 : 32'd5, 1'b0);
    end
    start_req(2'b11);
    wait_gnt("t2", 4);
    drain("t2", 300);

    // Zero-length job from requester 1
    cfg1 = mk_cfg(32'd0, 32'h20);
    push("t3_gnt", EV_GNT1, 2, 1'b1, 32'd0, 1'b0);
    push("t3_lenerr", EV_ZL1, 1, 1'b1, 32'd0, 1'b0);
    start_req(2'b10);
    wait_gnt("t3", 1);
    drain("t3", 50);
    cfg1 = mk_cfg(32'd5, 32'h20);

    // Fast core: done without visible busy
    mode = 1;
    push("t4_gnt", EV_GNT0, 2, 1'b0, 32'd8, 1'b0);
    push("t4_start", EV_CS, 2, 1'b0, 32'd8, 1'b0);
    push("t4_done", EV_JD0, 3, 1'b0, 32'd8, 1'b0);
    start_req(2'b01);
    wait_gnt("t4", 1);
    drain("t4", 60);

    // Hung core: watchdog expiry, sticky error
    mode = 2;
    push("t5_gnt", EV_GNT1, 2, 1'b1, 32'd5, 1'b0);
    push("t5_start", EV_CS, 2, 1'b1, 32'd5, 1'b0);
    push("t5_wdog_done", EV_JD1, 21, 1'b1, 32'd5, 1'b1);
    start_req(2'b10);
    wait_gnt("t5", 1);
    drain("t5", 100);
    repeat (5) tick();
    chk("t5_wdog_sticky", 160'(wdog_err), 160'd1);
    mode = 0;
    push("t5b_gnt", EV_GNT0, 2, 1'b0, 32'd8, 1'b1);
    push("t5b_start", EV_CS, 2, 1'b0, 32'd8, 1'b1);
    push("t5b_done", EV_JD0, 14, 1'b0, 32'd8, 1'b1);
    start_req(2'b01);
    wait_gnt("t5b", 1);
    drain("t5b", 100);

    // Reset mid-job in WAIT_DONE: abort without job_done
    do_reset("t6_pre_reset");
    push("t6_gnt", EV_GNT0, 2, 1'b0, 32'd8, 1'b0);
    push("t6_start", EV_CS, 2, 1'b0, 32'd8, 1'b0);
    start_req(2'b01);
    wait_gnt("t6", 1);
    begin
      int k = 0;
      while (!core_start && k < 20) begin @(negedge clk); k++; end
      chk("t6_saw_start", 160'(core_start), 160'd1);
    end
    repeat (8) tick();
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_midjob_reset");
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("t6_no_pending", 160'(sb.size()), 160'd0);
    push("t6b_gnt", EV_GNT1, 2, 1'b1, 32'd5, 1'b0);
    push("t6b_start", EV_CS, 2, 1'b1, 32'd5, 1'b0);
    push("t6b_done", EV_JD1, 14, 1'b1, 32'd5, 1'b0);
    start_req(2'b10);
    wait_gnt("t6b", 1);
    drain("t6b", 100);

    repeat (3) tick();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
